// File: rtl/ex_mem_if.sv
// EX -> EX/MEM boundary bundle: decoded EX slot plus ALU_Top results.
interface ex_mem_if #(
    parameter int XLEN = 64
);
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] alu_result;
    logic            zero_flag;
    logic            overflow_alu;

    modport master (
        output ex_valid, ex_pc, ex_opcode, ex_funct3, ex_rd,
        output ex_imm, ex_rs2_val, alu_result, zero_flag, overflow_alu
    );

    modport slave (
        input ex_valid, ex_pc, ex_opcode, ex_funct3, ex_rd,
        input ex_imm, ex_rs2_val, alu_result, zero_flag, overflow_alu
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with BEQ/BNE/JAL resolution, one-cycle
// redirect pulse and a squash FSM that bubbles wrong-path EX slots.
module ex_mem_stage #(
    parameter int XLEN          = 64,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    ex_mem_if.slave         ex,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_pc,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic [2:0]      mem_funct3,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_reg_write,
    output logic            mem_overflow,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            squash_active
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       load, take;
    logic       is_ld, is_st, is_jal, is_br;
    logic       writes_rd, taken;

    assign is_ld  = ex.ex_opcode == OP_LOAD;
    assign is_st  = ex.ex_opcode == OP_STORE;
    assign is_jal = ex.ex_opcode == OP_JAL;
    assign is_br  = ex.ex_opcode == OP_BR;

    assign writes_rd = (ex.ex_rd != 5'd0) &&
        (ex.ex_opcode inside {OP_REG, OP_IMM, OP_LOAD,
                              OP_JAL, OP_LUI, OP_AUIPC});

    // Only BEQ (000) and BNE (001) resolve here; other funct3 fall through.
    assign taken = is_jal ||
        (is_br && ex.ex_funct3 == 3'b000 && ex.zero_flag) ||
        (is_br && ex.ex_funct3 == 3'b001 && !ex.zero_flag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        take      = 1'b0;
        if (!stall) begin
            unique case (state)
                IDLE: begin
                    load = ex.ex_valid;
                    if (ex.ex_valid && taken) begin
                        take      = 1'b1;
                        state_nxt = SQUASH;
                        cnt_nxt   = 2'(SQUASH_CYCLES);
                    end
                end
                SQUASH: begin
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign squash_active = (state == SQUASH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid      <= 1'b0;
            mem_pc         <= '0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= 5'd0;
            mem_funct3     <= 3'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_overflow   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (stall) begin
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= take;
            if (take) redirect_pc <= ex.ex_pc + ex.ex_imm;
            mem_valid     <= load;
            mem_read      <= load & is_ld;
            mem_write     <= load & is_st;
            mem_reg_write <= load & writes_rd;
            if (load) begin
                mem_pc         <= ex.ex_pc;
                mem_result     <= is_jal ? ex.ex_pc + XLEN'(4)
                                         : ex.alu_result;
                mem_store_data <= ex.ex_rs2_val;
                mem_rd         <= ex.ex_rd;
                mem_funct3     <= ex.ex_funct3;
                mem_overflow   <= ex.overflow_alu;
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage against a
// behavioural model of the EX/MEM boundary.
module tb_ex_mem_stage;
    localparam int XLEN = 64;
    localparam int SQ   = 2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic clk = 0;
    logic reset, stall;
    logic            mem_valid, mem_read, mem_write, mem_reg_write;
    logic            mem_overflow, redirect_valid, squash_active;
    logic [XLEN-1:0] mem_pc, mem_result, mem_store_data, redirect_pc;
    logic [4:0]      mem_rd;
    logic [2:0]      mem_funct3;

    int checks = 0;
    int errors = 0;

    ex_mem_if #(.XLEN(XLEN)) exi ();

    ex_mem_stage #(.XLEN(XLEN), .SQUASH_CYCLES(SQ)) dut (
        .clk(clk), .reset(reset), .stall(stall), .ex(exi.slave),
        .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_funct3(mem_funct3),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_reg_write(mem_reg_write), .mem_overflow(mem_overflow),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .squash_active(squash_active)
    );

    always #5 clk = ~clk;

    // Model state
    int          sq_left;
    logic        e_valid, e_read, e_write, e_rw, e_ovf, e_rv;
    logic [63:0] e_pc, e_res, e_st, e_rpc;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sq_left = 0;
        {e_valid, e_read, e_write, e_rw, e_ovf, e_rv} = '0;
        {e_pc, e_res, e_st, e_rpc} = '0;
        e_rd = 0;
        e_f3 = 0;
    endtask

    task automatic model_step();
        bit tk;
        e_rv = 0;
        if (stall) return;
        if (sq_left > 0) begin
            sq_left--;
            {e_valid, e_read, e_write, e_rw} = '0;
        end else if (!exi.ex_valid) begin
            {e_valid, e_read, e_write, e_rw} = '0;
        end else begin
            e_valid = 1;
            e_read  = exi.ex_opcode == OP_LOAD;
            e_write = exi.ex_opcode == OP_STORE;
            e_rw    = exi.ex_rd != 0 &&
                      (exi.ex_opcode == OP_REG || exi.ex_opcode == OP_IMM ||
                       exi.ex_opcode == OP_LOAD || exi.ex_opcode == OP_JAL ||
                       exi.ex_opcode == OP_LUI || exi.ex_opcode == OP_AUIPC);
            e_pc  = exi.ex_pc;
            e_res = exi.ex_opcode == OP_JAL ? exi.ex_pc + 4 : exi.alu_result;
            e_st  = exi.ex_rs2_val;
            e_rd  = exi.ex_rd;
            e_f3  = exi.ex_funct3;
            e_ovf = exi.overflow_alu;
            tk = exi.ex_opcode == OP_JAL ||
                 (exi.ex_opcode == OP_BR && exi.ex_funct3 == 0 &&  exi.zero_flag) ||
                 (exi.ex_opcode == OP_BR && exi.ex_funct3 == 1 && !exi.zero_flag);
            if (tk) begin
                e_rv    = 1;
                e_rpc   = exi.ex_pc + exi.ex_imm;
                sq_left = SQ;
            end
        end
    endtask

    task automatic compare();
        chk("mem_valid", mem_valid, e_valid);
        chk("mem_read", mem_read, e_read);
        chk("mem_write", mem_write, e_write);
        chk("mem_reg_write", mem_reg_write, e_rw);
        chk("redirect_valid", redirect_valid, e_rv);
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("squash_active", squash_active, sq_left > 0);
        if (e_valid) begin
            chk("mem_pc", mem_pc, e_pc);
            chk("mem_result", mem_result, e_res);
            chk("mem_store_data", mem_store_data, e_st);
            chk("mem_rd", mem_rd, e_rd);
            chk("mem_funct3", mem_funct3, e_f3);
            chk("mem_overflow", mem_overflow, e_ovf);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_ex(logic v, logic [6:0] op, logic [2:0] f3,
                          logic [4:0] rd, logic [63:0] pc,
                          logic [63:0] imm, logic [63:0] alu, logic z);
        exi.ex_valid     = v;
        exi.ex_opcode    = op;
        exi.ex_funct3    = f3;
        exi.ex_rd        = rd;
        exi.ex_pc        = pc;
        exi.ex_imm       = imm;
        exi.alu_result   = alu;
        exi.zero_flag    = z;
        exi.ex_rs2_val   = {$urandom, $urandom};
        exi.overflow_alu = 1'($urandom);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, " zero ctl"},
            {63'd0, |{mem_valid, mem_read, mem_write, mem_reg_write,
                      mem_overflow, redirect_valid, squash_active}}, 64'd0);
        chk({tag, " zero data"},
            mem_pc | mem_result | mem_store_data | redirect_pc |
            {56'd0, mem_rd, mem_funct3}, 64'd0);
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{OP_LOAD, OP_STORE, OP_BR, OP_BR, OP_JAL, OP_REG,
                OP_IMM, OP_LUI, OP_AUIPC, 7'b1110011};
        model_reset();
        stall = 0;
        set_ex(0, OP_REG, 0, 0, 0, 0, 0, 0);
        reset = 1;
        #2;
        check_all_zero("por");
        @(negedge clk);
        reset = 0;

        // ADD
        set_ex(1, OP_REG, 0, 5, 64'h40, 0, 64'h2A, 0);
        cycle();
        chk("add result lit", mem_result, 64'h2A);
        chk("add rw lit", mem_reg_write, 1);

        // BEQ taken, then 3 instructions: 2 squashed, third lands
        set_ex(1, OP_BR, 3'b000, 0, 64'h100, 64'h8, 0, 1);
        cycle();
        chk("beq rv lit", redirect_valid, 1);
        chk("beq rpc lit", redirect_pc, 64'h108);
        for (int i = 0; i < 3; i++) begin
            set_ex(1, OP_REG, 0, 7, 64'h104 + 4 * i, 0, i, 0);
            cycle();
            chk("beq follow valid lit", mem_valid, i == 2);
            chk("beq pulse lit", redirect_valid, 0);
        end

        // BNE backward, taken
        set_ex(1, OP_BR, 3'b001, 0, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
        cycle();
        chk("bne rpc lit", redirect_pc, 64'h1F8);
        set_ex(0, OP_REG, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        // BNE not taken
        set_ex(1, OP_BR, 3'b001, 0, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1);
        cycle();
        chk("bne nt sq lit", squash_active, 0);
        chk("bne nt rv lit", redirect_valid, 0);

        // JAL
        set_ex(1, OP_JAL, 0, 1, 64'h1000, 64'h1000, 64'h55, 0);
        cycle();
        chk("jal res lit", mem_result, 64'h1004);
        chk("jal rw lit", mem_reg_write, 1);
        chk("jal rpc lit", redirect_pc, 64'h2000);
        set_ex(0, OP_REG, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        // Taken BEQ with a 3-cycle stall inside SQUASH
        set_ex(1, OP_BR, 3'b000, 0, 64'h300, 64'h40, 0, 1);
        cycle();
        set_ex(1, OP_REG, 0, 9, 64'h304, 0, 64'h77, 0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall sq lit", squash_active, 1);
            chk("stall rv lit", redirect_valid, 0);
        end
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post-stall valid lit", mem_valid, i == 2);
        end

        // Load rd=0, store, wrapping BEQ
        set_ex(1, OP_LOAD, 3'b011, 0, 64'h400, 0, 64'h800, 0);
        cycle();
        chk("ld read lit", mem_read, 1);
        chk("ld rw lit", mem_reg_write, 0);
        set_ex(1, OP_STORE, 3'b011, 0, 64'h404, 0, 64'h808, 0);
        exi.ex_rs2_val = 64'hDEAD_BEEF_0123_4567;
        cycle();
        chk("st write lit", mem_write, 1);
        chk("st data lit", mem_store_data, 64'hDEAD_BEEF_0123_4567);
        set_ex(1, OP_BR, 3'b000, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0, 1);
        cycle();
        chk("wrap rpc lit", redirect_pc, 64'h4);

        // Randomized traffic with a reset dropped in mid-stream
        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(9)];
            set_ex($urandom_range(9) < 8, op, 3'($urandom_range(7)),
                   5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 1'($urandom));
            if (op == OP_BR) exi.ex_funct3 = 3'($urandom_range(2));
            stall = $urandom_range(4) == 0;
            if (n == 300) begin
                #2;
                reset = 1;
                #1;
                check_all_zero("mid reset");
                model_reset();
                @(negedge clk);
                reset = 0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
